// File: rtl/pwm_gen_if.sv
// PWM output-stage bus: counter snapshot and shadow settings in, waveform and status out.
interface pwm_gen_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic [WIDTH-1:0] count_val;
    logic [WIDTH-1:0] period;
    logic             upnotdown;
    logic             pwm_en;
    logic [1:0]       functions;
    logic [WIDTH-1:0] compare1;
    logic [WIDTH-1:0] compare2;
    logic             pwm_out;
    logic             period_start;
    logic             upd_pending;

    // Driver side: counter stage plus software registers.
    modport master (
        output count_val,
        output period,
        output upnotdown,
        output pwm_en,
        output functions,
        output compare1,
        output compare2,
        input  pwm_out,
        input  period_start,
        input  upd_pending
    );

    // PWM output stage.
    modport slave (
        input  count_val,
        input  period,
        input  upnotdown,
        input  pwm_en,
        input  functions,
        input  compare1,
        input  compare2,
        output pwm_out,
        output period_start,
        output upd_pending
    );

endinterface

// File: rtl/pwm_gen.sv
// PWM output stage: double-buffered compare/mode settings, registered waveform output.
module pwm_gen #(
    parameter int unsigned WIDTH      = 16,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    pwm_gen_if.slave  pwm_io
);

    logic [WIDTH-1:0] prev_cnt_q, prev_cnt_d;
    logic [WIDTH-1:0] act_cmp1_q, act_cmp1_d;
    logic [WIDTH-1:0] act_cmp2_q, act_cmp2_d;
    logic [1:0]       act_func_q, act_func_d;
    logic             pwm_out_q, pwm_out_d;
    logic             period_start_q, period_start_d;
    logic             upd_pending_q, upd_pending_d;

    logic             chg;
    logic             bnd;
    logic             load;
    logic [WIDTH-1:0] eff_cmp1;
    logic [WIDTH-1:0] eff_cmp2;
    logic [1:0]       eff_func;
    logic             level;

    // Boundary detection, shadow selection, comparison and next-state.
    always_comb begin
        chg            = 1'b0;
        bnd            = 1'b0;
        load           = 1'b0;
        eff_cmp1       = act_cmp1_q;
        eff_cmp2       = act_cmp2_q;
        eff_func       = act_func_q;
        level          = 1'b0;
        prev_cnt_d     = pwm_io.count_val;
        act_cmp1_d     = act_cmp1_q;
        act_cmp2_d     = act_cmp2_q;
        act_func_d     = act_func_q;
        pwm_out_d      = IDLE_LEVEL;
        period_start_d = 1'b0;
        upd_pending_d  = 1'b0;

        // The prescaler holds values for many cycles, so only a value change can mark a boundary.
        chg  = (pwm_io.count_val != prev_cnt_q);
        bnd  = chg && ((pwm_io.upnotdown && (pwm_io.count_val == '0)) ||
                       (!pwm_io.upnotdown && (pwm_io.count_val == pwm_io.period)));
        load = bnd || !pwm_io.pwm_en;

        // Bypass the shadow on load so the first count of a new period uses the new settings.
        if (load) begin
            eff_cmp1   = pwm_io.compare1;
            eff_cmp2   = pwm_io.compare2;
            eff_func   = pwm_io.functions;
            act_cmp1_d = pwm_io.compare1;
            act_cmp2_d = pwm_io.compare2;
            act_func_d = pwm_io.functions;
        end

        if (eff_func[1]) begin
            level = (eff_cmp1 <= pwm_io.count_val) && (pwm_io.count_val < eff_cmp2);
        end else if (eff_func[0]) begin
            level = (pwm_io.count_val >= eff_cmp1);
        end else begin
            level = (pwm_io.count_val < eff_cmp1);
        end

        pwm_out_d      = pwm_io.pwm_en ? level : IDLE_LEVEL;
        period_start_d = bnd && pwm_io.pwm_en;
        upd_pending_d  = pwm_io.pwm_en && !load &&
                         ((pwm_io.compare1 != act_cmp1_q) ||
                          (pwm_io.compare2 != act_cmp2_q) ||
                          (pwm_io.functions != act_func_q));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cnt_q     <= '0;
            act_cmp1_q     <= '0;
            act_cmp2_q     <= '0;
            act_func_q     <= '0;
            pwm_out_q      <= IDLE_LEVEL;
            period_start_q <= 1'b0;
            upd_pending_q  <= 1'b0;
        end else begin
            prev_cnt_q     <= prev_cnt_d;
            act_cmp1_q     <= act_cmp1_d;
            act_cmp2_q     <= act_cmp2_d;
            act_func_q     <= act_func_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
            upd_pending_q  <= upd_pending_d;
        end
    end

    assign pwm_io.pwm_out      = pwm_out_q;
    assign pwm_io.period_start = period_start_q;
    assign pwm_io.upd_pending  = upd_pending_q;

endmodule
